// File: rtl/bus_arbiter.sv
// Two-master (CPU/DMA) arbiter for a shared 8-bit asynchronous-style memory bus.
// CPU has fixed priority; DMA is forced in after MAX_BURST back-to-back CPU grants
// made while DMA was waiting. Each transfer: IDLE -> ACCESS (strobe) -> ACK -> IDLE.
module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [15:0] adress_bus,
  inout  wire  [7:0]  date_bus,
  output logic        r,
  output logic        w,
  output logic        owner,
  output logic        busy
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);
  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        r_q, r_d;
  logic        w_q, w_d;
  logic        owner_q, owner_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  streak_q, streak_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;

  // DMA wins only when CPU is silent or the CPU streak has used up its burst allowance.
  logic sel_dma;
  assign sel_dma = dma_req && (!cpu_req || (streak_q == BurstMax));

  // Next-state and datapath updates for the three-state transfer FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    r_d         = r_q;
    w_d         = w_q;
    owner_d     = owner_q;
    wait_d      = wait_q;
    streak_d    = streak_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || dma_req) begin
          if (sel_dma) begin
            addr_d   = dma_addr;
            wdata_d  = dma_wdata;
            we_d     = dma_we;
            owner_d  = 1'b1;
            streak_d = 4'd0;
          end else begin
            addr_d   = cpu_addr;
            wdata_d  = cpu_wdata;
            we_d     = cpu_we;
            owner_d  = 1'b0;
            streak_d = dma_req ? streak_q + 4'd1 : 4'd0;
          end
          r_d     = !we_d;
          w_d     = we_d;
          wait_d  = WaitInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          r_d = 1'b0;
          w_d = 1'b0;
          if (owner_q) begin
            dma_ack_d = 1'b1;
            if (!we_q) dma_rdata_d = date_bus;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = date_bus;
          end
          state_d = StAck;
        end
      end
      StAck: begin
        // Ack lasts one cycle; no arbitration here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; asynchronous reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      r_q         <= 1'b0;
      w_q         <= 1'b0;
      owner_q     <= 1'b0;
      wait_q      <= 4'd0;
      streak_q    <= 4'd0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      r_q         <= r_d;
      w_q         <= w_d;
      owner_q     <= owner_d;
      wait_q      <= wait_d;
      streak_q    <= streak_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign date_bus   = w_q ? wdata_q : 8'hzz;
  assign adress_bus = addr_q;
  assign r          = r_q;
  assign w          = w_q;
  assign owner      = owner_q;
  assign busy       = (state_q != StIdle);
  assign cpu_ack    = cpu_ack_q;
  assign dma_ack    = dma_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a transfer table plus hand-written multi-cycle sequences.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, dma_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0, dma_wdata = 8'h0;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        cpu_ack, dma_ack, r, w, owner, busy;
  logic [15:0] adress_bus;
  wire  [7:0]  date_bus;
  logic [7:0]  mem_q = 8'h00;

  // Second instance with zero wait states, CPU side only.
  logic        c2_req = 1'b0, c2_we = 1'b0;
  logic [15:0] c2_addr = 16'h0;
  logic [7:0]  c2_wdata = 8'h0;
  logic [7:0]  c2_rdata, d2_rdata;
  logic        c2_ack, d2_ack, r2, w2, owner2, busy2;
  logic [15:0] adress_bus2;
  wire  [7:0]  date_bus2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: drives read data whenever the read strobe is up.
  assign date_bus = r ? mem_q : 8'hzz;

  bus_arbiter #(.WAIT_CYCLES(1), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .adress_bus(adress_bus), .date_bus(date_bus), .r(r), .w(w), .owner(owner), .busy(busy)
  );

  bus_arbiter #(.WAIT_CYCLES(0), .MAX_BURST(4)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(c2_req), .cpu_addr(c2_addr), .cpu_wdata(c2_wdata), .cpu_we(c2_we),
    .cpu_rdata(c2_rdata), .cpu_ack(c2_ack),
    .dma_req(1'b0), .dma_addr(16'h0000), .dma_wdata(8'h00), .dma_we(1'b0),
    .dma_rdata(d2_rdata), .dma_ack(d2_ack),
    .adress_bus(adress_bus2), .date_bus(date_bus2), .r(r2), .w(w2), .owner(owner2),
    .busy(busy2)
  );

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mem;
    logic [7:0]  exp_cpu;
    logic [7:0]  exp_dma;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One single-requester transfer from the table, checked cycle by cycle.
  task automatic do_xfer(input vec_t v);
    int ack_edge;
    int strobes;
    logic my_ack;
    ack_edge = 0;
    strobes  = 0;
    @(negedge clk);
    mem_q = v.mem;
    if (v.is_dma) begin
      dma_addr = v.addr; dma_wdata = v.wdata; dma_we = v.we; dma_req = 1'b1;
    end else begin
      cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_we = v.we; cpu_req = 1'b1;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (r || w) begin
        strobes++;
        check("strobe_dir", {r, w}, v.we ? 32'd1 : 32'd2);
        check("addr_during_strobe", adress_bus, v.addr);
        if (w) check("wdata_on_bus", date_bus, v.wdata);
      end
      my_ack = v.is_dma ? dma_ack : cpu_ack;
      if (my_ack) begin
        ack_edge = c;
        break;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    check("ack_latency", ack_edge, 3);
    check("strobe_cycles", strobes, 2);
    check("other_ack_low", v.is_dma ? cpu_ack : dma_ack, 1'b0);
    check("owner", owner, v.is_dma);
    check("cpu_rdata", cpu_rdata, v.exp_cpu);
    check("dma_rdata", dma_rdata, v.exp_dma);
    @(posedge clk);
    #1;
    check("ack_cleared", {cpu_ack, dma_ack}, 0);
    check("idle_not_busy", busy, 1'b0);
    check("addr_retained", adress_bus, v.addr);
  endtask

  // Global timeout so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] order;
    int grants;
    int ack_edge;
    int strobes;
    logic got_cpu;

    vecs[0] = '{1'b0, 1'b0, 16'h2000, 8'h00, 8'hA5, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 8'h3C, 8'h00, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 16'h0F0F, 8'h00, 8'h5A, 8'hA5, 8'h5A};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 8'h77, 8'h00, 8'hA5, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 16'hABCD, 8'h00, 8'hC3, 8'h00, 8'hC3};
    vecs[6] = '{1'b0, 1'b0, 16'h8001, 8'h00, 8'hFF, 8'hFF, 8'hC3};

    // Reset state
    #1;
    check("rst_strobes", {r, w}, 0);
    check("rst_acks", {cpu_ack, dma_ack}, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    check("rst_addr", adress_bus, 16'h0000);
    check("rst_owner_busy", {owner, busy}, 0);
    do_reset();

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Simultaneous requests: CPU first, then DMA on the next IDLE.
    do_reset();
    @(negedge clk);
    mem_q = 8'h42;
    cpu_addr = 16'h0C00; cpu_we = 1'b0;
    dma_addr = 16'h0D00; dma_we = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1;
    @(posedge clk);
    #1;
    check("sim_first_owner", {owner, r}, 2'b01);
    check("sim_first_addr", adress_bus, 16'h0C00);
    got_cpu = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (cpu_ack || dma_ack) begin
        got_cpu = cpu_ack && !dma_ack;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("sim_first_is_cpu", got_cpu, 1'b1);
    cpu_req = 1'b0;
    got_cpu = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (cpu_ack || dma_ack) begin
        got_cpu = cpu_ack;
        break;
      end
    end
    check("sim_second_is_dma", {got_cpu, dma_ack, owner}, 3'b011);
    dma_req = 1'b0;

    // Both held continuously: expect C,C,C,C,D,C,C,C,C,D.
    do_reset();
    order = 10'b10_0001_0000;
    grants = 0;
    @(negedge clk);
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (cpu_ack || dma_ack) begin
        check("burst_order", {cpu_ack, dma_ack}, order[grants] ? 32'd1 : 32'd2);
        check("burst_owner", owner, order[grants]);
        grants++;
        if (grants == 10) break;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check("burst_grants", grants, 10);

    // Reset during second strobe cycle of a CPU read, then immediate arbitration on release.
    do_reset();
    @(negedge clk);
    mem_q = 8'h99;
    cpu_addr = 16'h5555; cpu_we = 1'b0; cpu_req = 1'b1;
    @(posedge clk);
    #1;
    check("abort_strobe1", r, 1'b1);
    @(posedge clk);
    #1;
    check("abort_strobe2", r, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_r_low", {r, w}, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_no_ack", cpu_ack, 1'b0);
    check("abort_rdata", cpu_rdata, 8'h00);
    check("abort_addr", adress_bus, 16'h0000);
    @(posedge clk);
    #1;
    check("abort_no_ack_later", cpu_ack, 1'b0);
    @(negedge clk);
    cpu_addr = 16'h4444;
    mem_q = 8'h6B;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("release_grant", {r, busy}, 2'b11);
    check("release_addr", adress_bus, 16'h4444);
    ack_edge = 0;
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (cpu_ack) begin
        ack_edge = c;
        break;
      end
    end
    cpu_req = 1'b0;
    check("release_ack_latency", ack_edge, 3);
    check("release_rdata", cpu_rdata, 8'h6B);

    // Zero-wait build: single CPU write.
    @(negedge clk);
    c2_addr = 16'h0ABC; c2_wdata = 8'hE7; c2_we = 1'b1; c2_req = 1'b1;
    ack_edge = 0;
    strobes = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (w2) begin
        strobes++;
        check("w0_bus", date_bus2, 8'hE7);
        check("w0_addr", adress_bus2, 16'h0ABC);
      end
      if (c2_ack) begin
        ack_edge = c;
        break;
      end
    end
    c2_req = 1'b0;
    check("w0_strobe_cycles", strobes, 1);
    check("w0_ack_latency", ack_edge, 2);
    check("w0_rdata_kept", c2_rdata, 8'h00);
    @(posedge clk);
    #1;
    check("w0_idle", {busy2, c2_ack}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
